palette_ctrl: RTL and testbench

Palette controller for the VGA color path. It holds a 16-entry 24-bit color palette and maps a per-pixel color index from the drawing logic to VGA_R/G/B with one cycle of latency. Software-side palette writes are queued in a small FIFO and committed only while `vblank` is high, so no palette entry changes during active video.

---
 rtl/palette_ctrl.sv | 123 ++++++++++++
 tb/tb_palette_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/palette_ctrl.sv
// Palette controller: 16x24-bit color palette with a 1-cycle lookup path and a
// write queue that only drains into the palette while vblank is high.
module palette_ctrl #(
  parameter int NUM_ENTRIES = 16,
  parameter int QDEPTH      = 4,
  localparam int IDX_W      = $clog2(NUM_ENTRIES),
  localparam int CNT_W      = $clog2(QDEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [23:0]      wr_rgb,
  input  logic             vblank,
  input  logic             pix_valid,
  input  logic [IDX_W-1:0] pix_idx,
  output logic             out_valid,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B,
  output logic [CNT_W-1:0] pending,
  output logic             commit_done
);
  localparam int PTR_W  = $clog2(QDEPTH);
  localparam int STAGES = 1;
  localparam logic [CNT_W-1:0] QD  = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [23:0]      rgb;
  } wr_req_t;

  typedef enum logic [1:0] {IDLE, COMMIT, DONE} state_t;

  state_t           state, state_nxt;
  wr_req_t          q_mem [QDEPTH];
  wr_req_t          head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [23:0]      palette [NUM_ENTRIES];
  logic [23:0]      rgb_q;
  logic [STAGES:1]  vld_pipe;
  logic             push, pop, cd_q;

  assign wr_ready = count < QD;
  assign push     = wr_valid && wr_ready;
  assign pop      = (state == COMMIT) && vblank && (count != '0);
  assign head     = q_mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vblank && count != '0) state_nxt = COMMIT;
      COMMIT: begin
        if (!vblank)                             state_nxt = IDLE;
        else if (pop && !push && count == ONE)   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cd_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cd_q  <= (state_nxt == DONE);
    end
  end

  // Queue payload needs no reset; pointers and count define what is live.
  always_ff @(posedge Clk) begin
    if (push) q_mem[wr_ptr] <= '{idx: wr_idx, rgb: wr_rgb};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) palette[i] <= 24'h00_00_00;
      palette[0] <= 24'h3F_00_7F;
      palette[1] <= 24'hFF_FF_FF;
    end else if (pop) begin
      palette[head.idx] <= head.rgb;
    end
  end

  // Lookup reads the pre-commit palette, so a same-cycle commit shows the old color.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q    <= '0;
      vld_pipe <= '0;
    end else begin
      rgb_q    <= pix_valid ? palette[pix_idx] : 24'h00_00_00;
      vld_pipe <= STAGES'({vld_pipe, pix_valid});
    end
  end

  assign out_valid   = vld_pipe[STAGES];
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign pending     = count;
  assign commit_done = cd_q;
endmodule

// File: tb/tb_palette_ctrl.sv
// Directed bench for palette_ctrl: lookups feed a scoreboard checked by a monitor,
// queue/commit status is checked inline by the driver.
module tb_palette_ctrl;
  logic        Clk = 0, Reset_n = 1, wr_valid = 0, vblank = 0, pix_valid = 0;
  logic [3:0]  wr_idx = 0, pix_idx = 0;
  logic [23:0] wr_rgb = 0;
  logic        wr_ready, out_valid, commit_done;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic [2:0]  pending;

  int          checks = 0, failures = 0, cd_cnt = 0;
  bit          mon_en = 0;
  logic [23:0] exp_q[$];
  logic [23:0] rgb5 [5] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h888888};
  int          pend_a [6] = '{4, 3, 3, 2, 1, 0};

  always #5 Clk = ~Clk;

  palette_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_rgb(wr_rgb), .vblank(vblank), .pix_valid(pix_valid),
    .pix_idx(pix_idx), .out_valid(out_valid), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .pending(pending), .commit_done(commit_done)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  task automatic look(logic [3:0] idx, logic [23:0] exp);
    pix_valid = 1; pix_idx = idx; exp_q.push_back(exp);
    cyc();
    pix_valid = 0;
  endtask

  task automatic push(logic [3:0] idx, logic [23:0] rgb);
    wr_valid = 1; wr_idx = idx; wr_rgb = rgb;
    cyc();
    wr_valid = 0;
  endtask

  // Monitor: one result per out_valid, popped in request order.
  always @(posedge Clk) begin
    #1;
    if (mon_en && Reset_n) begin
      if (commit_done) cd_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("out_valid without request", out_valid, 0);
        else chk("vga lookup", {VGA_R, VGA_G, VGA_B}, exp_q.pop_front());
      end else begin
        chk("vga black when idle", {VGA_R, VGA_G, VGA_B}, 0);
      end
    end
  end

  initial begin
    // reset defaults, asserted mid-cycle
    #13 Reset_n = 0;
    #1;
    chk("rst pending", pending, 0);
    chk("rst wr_ready", wr_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst commit_done", commit_done, 0);
    chk("rst vga", {VGA_R, VGA_G, VGA_B}, 0);
    cyc();
    Reset_n = 1; mon_en = 1;
    look(0, 24'h3F007F);
    look(1, 24'hFFFFFF);
    look(5, 24'h000000);
    cyc();
    chk("idle pending", pending, 0);
    chk("idle wr_ready", wr_ready, 1);

    // gated commit
    push(2, 24'h123456);
    chk("gated pending", pending, 1);
    look(2, 24'h000000);
    vblank = 1;
    cyc();
    chk("gated pending in commit", pending, 1);
    look(2, 24'h000000);
    chk("gated pending after pop", pending, 0);
    chk("gated commit_done", commit_done, 1);
    chk("gated cd count", cd_cnt, 1);
    cyc();
    chk("gated commit_done drop", commit_done, 0);
    vblank = 0;
    look(2, 24'h123456);

    // full queue, 5th write held until a pop
    wr_valid = 1;
    for (int i = 0; i < 5; i++) begin
      wr_idx = 4'(4 + i); wr_rgb = rgb5[i];
      cyc();
      chk("full wr_ready", wr_ready, (i < 3) ? 1 : 0);
      chk("full pending", pending, (i < 4) ? i + 1 : 4);
    end
    vblank = 1;
    for (int j = 0; j < 6; j++) begin
      cyc();
      chk("drain pending", pending, pend_a[j]);
      if (j == 1) chk("drain wr_ready after pop", wr_ready, 1);
      if (j == 2) wr_valid = 0;
    end
    chk("drain commit_done", commit_done, 1);
    chk("drain cd count", cd_cnt, 2);
    cyc();
    vblank = 0;
    look(4, 24'h111111);
    look(7, 24'h444444);
    look(8, 24'h888888);

    // vblank interruption after 2 pops
    push(9, 24'hA1A1A1); push(10, 24'hB2B2B2); push(11, 24'hC3C3C3); push(12, 24'hD4D4D4);
    chk("intr pending", pending, 4);
    vblank = 1;
    cyc(); chk("intr pending c1", pending, 4);
    cyc(); chk("intr pending c2", pending, 3);
    cyc(); chk("intr pending c3", pending, 2);
    vblank = 0;
    cyc();
    chk("intr pending held", pending, 2);
    chk("intr no commit_done", commit_done, 0);
    chk("intr cd count", cd_cnt, 2);
    look(9, 24'hA1A1A1);
    look(10, 24'hB2B2B2);
    look(11, 24'h000000);
    vblank = 1;
    cyc(); chk("resume pending c1", pending, 2);
    cyc(); chk("resume pending c2", pending, 1);
    cyc(); chk("resume pending c3", pending, 0);
    chk("resume commit_done", commit_done, 1);
    chk("resume cd count", cd_cnt, 3);
    vblank = 0;
    look(11, 24'hC3C3C3);
    look(12, 24'hD4D4D4);

    // same-index ordering, push during COMMIT
    push(3, 24'hAAAAAA); push(3, 24'h555555);
    chk("dup pending", pending, 2);
    vblank = 1;
    cyc();
    wr_valid = 1; wr_idx = 13; wr_rgb = 24'h777777;
    look(3, 24'h000000);
    wr_valid = 0;
    chk("dup pending push+pop", pending, 2);
    look(3, 24'hAAAAAA);
    chk("dup pending c3", pending, 1);
    cyc();
    chk("dup pending c4", pending, 0);
    chk("dup commit_done", commit_done, 1);
    chk("dup cd count", cd_cnt, 4);
    vblank = 0;
    look(3, 24'h555555);
    look(13, 24'h777777);

    // reset mid-commit
    push(2, 24'hEEEEEE); push(1, 24'h000001); push(0, 24'h000002);
    vblank = 1;
    cyc(2);
    chk("midrst pending before", pending, 2);
    #2 Reset_n = 0;
    #1;
    chk("midrst pending", pending, 0);
    chk("midrst wr_ready", wr_ready, 1);
    chk("midrst commit_done", commit_done, 0);
    chk("midrst out_valid", out_valid, 0);
    vblank = 0;
    cyc();
    Reset_n = 1;
    cyc(3);
    chk("midrst pending after", pending, 0);
    chk("midrst cd count", cd_cnt, 4);
    look(0, 24'h3F007F);
    look(1, 24'hFFFFFF);
    look(2, 24'h000000);
    cyc(2);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
